// File: rtl/unidad_mult_div_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes, FSM states, datapath width.
// Also holds the small helpers used to decode the op and to take magnitudes of signed operands.
package pkg_mips;

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  function automatic logic es_division(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic es_con_signo(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic con_signo);
    return (con_signo && x[DATA_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/unidad_mult_div_paso.sv
// One combinational iteration of the mult/div datapath: shift-add multiply or restoring divide.
// Purely combinational, no state; the caller registers acc_next each RUN cycle.
module paso_mult_div
  import pkg_mips::*;
(
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   opnd,
  input  logic                es_div,
  input  logic                bit_in,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [DATA_W:0] suma;
  logic [DATA_W:0] resto;
  logic [DATA_W:0] dif;

  // Multiply: add into the upper half, then shift the 65-bit sum right so the product fills in from the top.
  // Divide: remainder lives in the upper half, quotient bits enter the lower half from the right.
  always_comb begin
    suma     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (bit_in ? {1'b0, opnd} : '0);
    resto    = {acc[2*DATA_W-1:DATA_W], bit_in};
    dif      = resto - {1'b0, opnd};
    acc_next = {suma, acc[DATA_W-1:1]};
    if (es_div) begin
      if (resto >= {1'b0, opnd})
        acc_next = {dif[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else
        acc_next = {resto[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unidad_mult_div.sv
// Iterative 32-step MULT/MULTU/DIV/DIVU unit with MTHI/MTLO; start-to-result latency 33 cycles.
// No backpressure: start and writes are only honoured in IDLE, caller stalls while busy.
module unidad_mult_div #(
  parameter int OP_W   = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic              start,
  input  logic              wr_hi,
  input  logic              wr_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);
  import pkg_mips::*;

  logic [1:0]          state;
  logic [4:0]          cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic                es_div;
  logic                neg_res;
  logic                neg_rem;
  logic                div_cero;
  logic                con_signo;
  logic                op_div;

  assign con_signo = es_con_signo(op);
  assign op_div    = es_division(op);
  assign busy      = (state != IDLE);

  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  // Multiplier bits leave sreg LSB first; dividend bits leave MSB first.
  paso_mult_div u_paso (
    .acc      (acc),
    .opnd     (opnd),
    .es_div   (es_div),
    .bit_in   (es_div ? sreg[DATA_W-1] : sreg[0]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      sreg     <= '0;
      es_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_cero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            es_div   <= op_div;
            neg_res  <= con_signo & (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_rem  <= con_signo & a[DATA_W-1];
            div_cero <= op_div && (b == '0);
            opnd     <= op_div ? abs_val(b, con_signo) : abs_val(a, con_signo);
            sreg     <= op_div ? abs_val(a, con_signo) : abs_val(b, con_signo);
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        RUN: begin
          acc  <= acc_next;
          sreg <= es_div ? (sreg << 1) : (sreg >> 1);
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          // A zero divisor leaves |a| as remainder, so the sign fix restores a itself.
          if (es_div) begin
            hi <= rem;
            lo <= div_cero ? '1 : quo;
          end else begin
            hi <= prod[2*DATA_W-1:DATA_W];
            lo <= prod[DATA_W-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unidad_mult_div.md
# unidad_mult_div

Multi-cycle multiply/divide unit sitting directly downstream of the register bank: it takes the two read-port operands (rd1, rd2) and produces the MIPS HI/LO pair for MULT, MULTU, DIV and DIVU. It also supports the MTHI/MTLO writes from the register-bank write-data bus. An iterative 32-step datapath keeps area small. The control unit stalls on `busy` and reads HI/LO once `done` pulses.

## Interface
- OP_W, 2, width of operation select
- DATA_W, 32, operand / HI / LO width (only 32 supported)
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- a  input  32  operand A (from rd1)
- b  input  32  operand B (from rd2)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- start  input  1  begin operation; sampled only in IDLE
- wr_hi  input  1  MTHI: load HI from a; honoured only in IDLE
- wr_lo  input  1  MTLO: load LO from a; honoured only in IDLE
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, HI/LO hold the new result

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch op, |a|, |b| (absolute values for signed ops only);
  - latch the result-sign flags;
  - clear the 64-bit accumulator and the 5-bit step counter;
  - go to RUN.
- RUN, multiply: shift-add, one bit of B per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first.
- RUN exit: after 32 steps (counter wraps 31→0), go to FIX.
- FIX, multiply: product negated if signs differ (signed only). HI=product[63:32], LO=product[31:0].
- FIX, divide: LO=quotient, HI=remainder.
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of a.
- FIX exit: write HI/LO, go to IDLE.
- Divide by zero (b=0), DIV and DIVU: completes with full latency, HI=a, LO=32'hFFFF_FFFF. No exception.
- DIV 0x8000_0000 / -1: LO=0x8000_0000, HI=0 (wrap, no trap).
- start while busy: ignored.
- wr_hi/wr_lo while busy: ignored.
- wr_hi/wr_lo in IDLE: take effect at the next edge. If start is also high in the same cycle, start wins and the writes are dropped.
- HI/LO change only at the FIX edge or on an honoured MTHI/MTLO write. Otherwise they hold.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE;
  - hi=0, lo=0, busy=0, done=0;
  - counter and accumulator cleared.
- Reset mid-operation aborts the operation, with the same values as above. No partial result reaches HI/LO.
- Edge E0 samples start: busy=1 from after E0.
- Edges E1..E32 perform the 32 RUN steps.
- Edge E33 (FIX):
  - HI/LO updated;
  - busy=0 and done=1 during the cycle after E33;
  - done returns to 0 after E34.
- Latency start→result: 33 cycles.
- Back-to-back: the next start can be sampled at E34, in the cycle where done=1.
- MTHI/MTLO latency: 1 cycle, with no busy and no done.
- Operands a/b need only be stable in the cycle start is sampled.

## Structure
- Shared package `pkg_mips`:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding (IDLE, RUN, FIX);
  - DATA_W.
- The step logic is natural as one combinational sub-module, `paso_mult_div`. It takes the accumulator, divisor/multiplicand and mode, and returns the next accumulator.
- The FSM, counter, sign fix and HI/LO registers stay in the top module.

## Test plan
- MULTU 0xFFFF_FFFF×0xFFFF_FFFF → after 33 cycles HI=0xFFFF_FFFE, LO=0x0000_0001, done pulses once.
- MULT -3×7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; DIVU 100/7 → LO=14, HI=2.
- DIV -7/2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); DIV 0x8000_0000/-1 → LO=0x8000_0000, HI=0.
- DIVU 5/0 → HI=5, LO=0xFFFF_FFFF after the full 33 cycles.
- Start MULT, then at cycle 10 assert start again (different operands) and wr_hi → both ignored, and the original result appears at cycle 33.
- Start DIV, drop rst_n at cycle 15 → hi=lo=0, busy=0, done never pulses. Then in IDLE, wr_lo with a=0x1234 → lo=0x1234 after one edge.
